// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB/MD) with a data-memory
// ready handshake. Define MC_CTRL_MD_EN to enable mult/div/mfhi/mflo and the MD sequencer.
module mc_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] NPCOp,
  output logic [1:0] RegDst,
  output logic       RFWr,
  output logic       ALUSrc,
  output logic [3:0] ALUOp,
  output logic       DMWr,
  output logic [2:0] DMOp,
  output logic [1:0] MemtoReg,
  output logic       EXTOp,
  output logic [1:0] CMPOp,
  output logic       MDStart,
  output logic       MDOp,
  output logic       HILOWr,
  output logic       HILOSel,
  output logic       md_busy,
  output logic       illegal
);

  typedef enum logic [2:0] {S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_MD} state_t;
  typedef enum logic [3:0] {C_ALU, C_LOAD, C_STORE, C_BEQ, C_J, C_JR, C_JAL, C_MD, C_MF, C_ILL} cls_t;

  state_t     state_reg, state_next;
  cls_t       cls;
  logic [1:0] d_regdst, d_memtoreg, d_cmpop;
  logic       d_alusrc, d_extop, d_mdop, d_hilosel;
  logic [3:0] d_aluop;
  logic [2:0] d_dmop;

  // Instruction class plus the static control fields held from ID to the end.
  always_comb begin
    cls        = C_ILL;
    d_regdst   = 2'b00;
    d_memtoreg = 2'b00;
    d_cmpop    = 2'b11;
    d_alusrc   = 1'b0;
    d_extop    = 1'b0;
    d_mdop     = 1'b0;
    d_hilosel  = 1'b0;
    d_aluop    = 4'd0;
    d_dmop     = 3'd0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21: begin cls = C_ALU; d_regdst = 2'b01; end
          6'h23: begin cls = C_ALU; d_regdst = 2'b01; d_aluop = 4'd1; end
          6'h00: begin cls = C_ALU; d_regdst = 2'b01; d_aluop = 4'd3; end
          6'h08: cls = C_JR;
`ifdef MC_CTRL_MD_EN
          6'h18: cls = C_MD;
          6'h1a: begin cls = C_MD; d_mdop = 1'b1; end
          6'h10: begin cls = C_MF; d_regdst = 2'b01; d_memtoreg = 2'b11; d_hilosel = 1'b1; end
          6'h12: begin cls = C_MF; d_regdst = 2'b01; d_memtoreg = 2'b11; end
`endif
          default: cls = C_ILL;
        endcase
      end
      6'h0d: begin cls = C_ALU; d_alusrc = 1'b1; d_aluop = 4'd2; end
      6'h0f: begin cls = C_ALU; d_alusrc = 1'b1; d_aluop = 4'd4; end
      6'h23, 6'h21, 6'h25, 6'h20, 6'h24: begin
        cls        = C_LOAD;
        d_alusrc   = 1'b1;
        d_extop    = 1'b1;
        d_memtoreg = 2'b01;
        case (opcode)
          6'h21:   d_dmop = 3'd1;
          6'h25:   d_dmop = 3'd2;
          6'h20:   d_dmop = 3'd3;
          6'h24:   d_dmop = 3'd4;
          default: d_dmop = 3'd0;
        endcase
      end
      6'h2b, 6'h29, 6'h28: begin
        cls      = C_STORE;
        d_alusrc = 1'b1;
        d_extop  = 1'b1;
        d_dmop   = (opcode == 6'h29) ? 3'd1 : (opcode == 6'h28) ? 3'd3 : 3'd0;
      end
      6'h04: begin cls = C_BEQ; d_extop = 1'b1; d_cmpop = 2'b00; d_aluop = 4'd1; end
      6'h02: cls = C_J;
      6'h03: begin cls = C_JAL; d_regdst = 2'b10; d_memtoreg = 2'b10; end
      default: cls = C_ILL;
    endcase
  end

`ifdef MC_CTRL_MD_EN
  localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW     = $clog2(MD_MAX) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

  logic [CW-1:0] md_cnt_reg, md_cnt_next, md_load;

  assign md_load = d_mdop ? DIV_LOAD : MULT_LOAD;

  // Loaded on MD entry, counts down to 0 inside MD, zero everywhere else.
  always_comb begin
    md_cnt_next = '0;
    if (state_reg == S_ID && cls == C_MD)
      md_cnt_next = md_load;
    else if (state_reg == S_MD && md_cnt_reg != '0)
      md_cnt_next = md_cnt_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_cnt_reg <= '0;
    else        md_cnt_reg <= md_cnt_next;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    NPCOp    = 2'b00;
    RegDst   = 2'b00;
    RFWr     = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 4'd0;
    DMWr     = 1'b0;
    DMOp     = 3'd0;
    MemtoReg = 2'b00;
    EXTOp    = 1'b0;
    CMPOp    = 2'b00;
    MDStart  = 1'b0;
    MDOp     = 1'b0;
    HILOWr   = 1'b0;
    HILOSel  = 1'b0;
    md_busy  = 1'b0;
    illegal  = 1'b0;

    if (state_reg inside {S_ID, S_EX, S_MEM, S_WB, S_MD}) begin
      RegDst   = d_regdst;
      ALUSrc   = d_alusrc;
      ALUOp    = d_aluop;
      DMOp     = d_dmop;
      MemtoReg = d_memtoreg;
      EXTOp    = d_extop;
      CMPOp    = d_cmpop;
      MDOp     = d_mdop;
      HILOSel  = d_hilosel;
    end

    case (state_reg)
      S_IDLE: state_next = S_IF;
      S_IF: begin
        IRWr       = 1'b1;
        state_next = S_ID;
      end
      S_ID: begin
        case (cls)
          C_ALU, C_LOAD, C_STORE, C_BEQ: state_next = S_EX;
          C_J:  begin PCWr = 1'b1; NPCOp = 2'b10; state_next = S_IF; end
          C_JR: begin PCWr = 1'b1; NPCOp = 2'b11; state_next = S_IF; end
          C_JAL, C_MF: state_next = S_WB;
          C_MD: state_next = S_MD;
          default: begin illegal = 1'b1; PCWr = 1'b1; state_next = S_IF; end
        endcase
      end
      S_EX: begin
        case (cls)
          C_BEQ: begin PCWr = 1'b1; NPCOp = 2'b01; state_next = S_IF; end
          C_LOAD, C_STORE: state_next = S_MEM;
          default: state_next = S_WB;
        endcase
      end
      S_MEM: begin
        DMWr = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            PCWr       = 1'b1;
            state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        RFWr       = 1'b1;
        PCWr       = 1'b1;
        NPCOp      = (cls == C_JAL) ? 2'b10 : 2'b00;
        state_next = S_IF;
      end
`ifdef MC_CTRL_MD_EN
      S_MD: begin
        md_busy = 1'b1;
        MDStart = (md_cnt_reg == md_load);
        if (md_cnt_reg == '0) begin
          HILOWr     = 1'b1;
          PCWr       = 1'b1;
          state_next = S_IF;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl; expected per-cycle outputs are
// derived from an instruction table plus latency rules. Honors MC_CTRL_MD_EN like the DUT.
module tb_mc_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int NINS     = 22;

  logic       clk, rst_n, mem_ready;
  logic [5:0] opcode, funct;
  logic       PCWr, IRWr, RFWr, ALUSrc, DMWr, EXTOp, MDStart, MDOp, HILOWr, HILOSel, md_busy, illegal;
  logic [1:0] NPCOp, RegDst, MemtoReg, CMPOp;
  logic [3:0] ALUOp;
  logic [2:0] DMOp;

  int vectors = 0;
  int miscompares = 0;

  mc_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp), .RegDst(RegDst), .RFWr(RFWr),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .DMWr(DMWr), .DMOp(DMOp), .MemtoReg(MemtoReg),
    .EXTOp(EXTOp), .CMPOp(CMPOp), .MDStart(MDStart), .MDOp(MDOp), .HILOWr(HILOWr),
    .HILOSel(HILOSel), .md_busy(md_busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [27:0] obs;
  assign obs = {PCWr, IRWr, NPCOp, RegDst, RFWr, ALUSrc, ALUOp, DMWr, DMOp, MemtoReg,
                EXTOp, CMPOp, MDStart, MDOp, HILOWr, HILOSel, md_busy, illegal};

  // cls: 0 fixed-latency, 1 load, 2 store, 3 mult/div
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [1:0] cls;
    logic [3:0] lat;
    logic       rf;
    logic       ill;
    logic [1:0] npc;
    logic [1:0] regdst;
    logic       alusrc;
    logic [3:0] aluop;
    logic [2:0] dmop;
    logic [1:0] m2r;
    logic       ext;
    logic [1:0] cmp;
    logic       mdop;
    logic       hisel;
  } ins_t;

  ins_t tbl [NINS];

  task automatic init_table();
    //            op     fn     cls   lat  rf ill npc    rd     src aluop dmop m2r   ext cmp   md hi
    tbl[0]  = '{6'h00, 6'h21, 2'd0, 4'd4, 1, 0, 2'b00, 2'b01, 0, 4'd0, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // addu
    tbl[1]  = '{6'h00, 6'h23, 2'd0, 4'd4, 1, 0, 2'b00, 2'b01, 0, 4'd1, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // subu
    tbl[2]  = '{6'h00, 6'h00, 2'd0, 4'd4, 1, 0, 2'b00, 2'b01, 0, 4'd3, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // sll
    tbl[3]  = '{6'h0d, 6'h15, 2'd0, 4'd4, 1, 0, 2'b00, 2'b00, 1, 4'd2, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // ori
    tbl[4]  = '{6'h0f, 6'h3c, 2'd0, 4'd4, 1, 0, 2'b00, 2'b00, 1, 4'd4, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // lui
    tbl[5]  = '{6'h23, 6'h04, 2'd1, 4'd5, 1, 0, 2'b00, 2'b00, 1, 4'd0, 3'd0, 2'b01, 1, 2'b11, 0, 0}; // lw
    tbl[6]  = '{6'h21, 6'h08, 2'd1, 4'd5, 1, 0, 2'b00, 2'b00, 1, 4'd0, 3'd1, 2'b01, 1, 2'b11, 0, 0}; // lh
    tbl[7]  = '{6'h25, 6'h10, 2'd1, 4'd5, 1, 0, 2'b00, 2'b00, 1, 4'd0, 3'd2, 2'b01, 1, 2'b11, 0, 0}; // lhu
    tbl[8]  = '{6'h20, 6'h01, 2'd1, 4'd5, 1, 0, 2'b00, 2'b00, 1, 4'd0, 3'd3, 2'b01, 1, 2'b11, 0, 0}; // lb
    tbl[9]  = '{6'h24, 6'h3f, 2'd1, 4'd5, 1, 0, 2'b00, 2'b00, 1, 4'd0, 3'd4, 2'b01, 1, 2'b11, 0, 0}; // lbu
    tbl[10] = '{6'h2b, 6'h00, 2'd2, 4'd4, 0, 0, 2'b00, 2'b00, 1, 4'd0, 3'd0, 2'b00, 1, 2'b11, 0, 0}; // sw
    tbl[11] = '{6'h29, 6'h18, 2'd2, 4'd4, 0, 0, 2'b00, 2'b00, 1, 4'd0, 3'd1, 2'b00, 1, 2'b11, 0, 0}; // sh
    tbl[12] = '{6'h28, 6'h21, 2'd2, 4'd4, 0, 0, 2'b00, 2'b00, 1, 4'd0, 3'd3, 2'b00, 1, 2'b11, 0, 0}; // sb
    tbl[13] = '{6'h04, 6'h0c, 2'd0, 4'd3, 0, 0, 2'b01, 2'b00, 0, 4'd1, 3'd0, 2'b00, 1, 2'b00, 0, 0}; // beq
    tbl[14] = '{6'h02, 6'h12, 2'd0, 4'd2, 0, 0, 2'b10, 2'b00, 0, 4'd0, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // j
    tbl[15] = '{6'h00, 6'h08, 2'd0, 4'd2, 0, 0, 2'b11, 2'b00, 0, 4'd0, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // jr
    tbl[16] = '{6'h03, 6'h2a, 2'd0, 4'd3, 1, 0, 2'b10, 2'b10, 0, 4'd0, 3'd0, 2'b10, 0, 2'b11, 0, 0}; // jal
    tbl[17] = '{6'h00, 6'h18, 2'd3, 4'd0, 0, 0, 2'b00, 2'b00, 0, 4'd0, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // mult
    tbl[18] = '{6'h00, 6'h1a, 2'd3, 4'd0, 0, 0, 2'b00, 2'b00, 0, 4'd0, 3'd0, 2'b00, 0, 2'b11, 1, 0}; // div
    tbl[19] = '{6'h00, 6'h10, 2'd0, 4'd3, 1, 0, 2'b00, 2'b01, 0, 4'd0, 3'd0, 2'b11, 0, 2'b11, 0, 1}; // mfhi
    tbl[20] = '{6'h00, 6'h12, 2'd0, 4'd3, 1, 0, 2'b00, 2'b01, 0, 4'd0, 3'd0, 2'b11, 0, 2'b11, 0, 0}; // mflo
    tbl[21] = '{6'h3f, 6'h21, 2'd0, 4'd2, 0, 1, 2'b00, 2'b00, 0, 4'd0, 3'd0, 2'b00, 0, 2'b11, 0, 0}; // unknown
  endtask

  // Without the MD feature, the MD-family instructions behave like any undecodable word.
  function automatic ins_t get_ins(input int idx);
    ins_t t;
    t = tbl[idx];
`ifndef MC_CTRL_MD_EN
    if (idx >= 17 && idx <= 20)
      t = '{tbl[idx].op, tbl[idx].fn, 2'd0, 4'd2, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'd0, 3'd0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0};
`endif
    return t;
  endfunction

  function automatic int ins_lat(input ins_t t, input int w);
    if (t.cls == 2'd3) return 2 + (t.mdop ? DIV_LAT : MULT_LAT);
    if (t.cls == 2'd1 || t.cls == 2'd2) return int'(t.lat) + w;
    return int'(t.lat);
  endfunction

  // Cycle c counts from 1 (IF) to lat (the PCWr cycle).
  function automatic logic [27:0] exp_vec(input ins_t t, input int lat, input int c);
    logic st, md;
    st = (c >= 2);
    md = (t.cls == 2'd3);
    return {c == lat, c == 1, (c == lat) ? t.npc : 2'b00,
            st ? t.regdst : 2'b00, t.rf && c == lat, st & t.alusrc, st ? t.aluop : 4'd0,
            t.cls == 2'd2 && c >= 4, st ? t.dmop : 3'd0, st ? t.m2r : 2'b00,
            st & t.ext, st ? t.cmp : 2'b00, md && c == 3, st & t.mdop,
            md && c == lat, st & t.hisel, md && c >= 3, t.ill && c == 2};
  endfunction

  // Runs one instruction cycle by cycle. abort_at > 0 drops rst_n mid-way through that cycle.
  task automatic run_instr(input int idx, input int w, input int abort_at);
    ins_t t;
    int lat, stop_at;
    logic [27:0] e;
    t = get_ins(idx);
    lat = ins_lat(t, w);
    stop_at = (abort_at > lat) ? lat : abort_at;
    $display("instr idx=%0d op=%02h fn=%02h w=%0d cycles=%0d abort=%0d", idx, t.op, t.fn, w, lat, stop_at);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        opcode = t.op;
        funct  = t.fn;
      end
      if ((t.cls == 2'd1 || t.cls == 2'd2) && c >= 4) mem_ready = (c == 4 + w);
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      e = exp_vec(t, lat, c);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL instr%0d cyc%0d: got %07h want %07h", idx, c, obs, e);
      end
      if (c == stop_at) begin
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 28'd0) begin
          miscompares++;
          $display("FAIL async_reset instr%0d cyc%0d: got %07h want 0000000", idx, c, obs);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (obs !== 28'd0) begin
          miscompares++;
          $display("FAIL idle_after_reset: got %07h want 0000000", obs);
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'h00;
    funct = 6'h21;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = 6'($urandom);
      funct = 6'($urandom);
      #1;
      vectors++;
      if (obs !== 28'd0) begin
        miscompares++;
        $display("FAIL reset_hold: got %07h want 0000000", obs);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (obs !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_idle: got %07h want 0000000", obs);
    end
  endtask

  task automatic test_alu();
    for (int i = 0; i <= 4; i++) run_instr(i, 0, 0);
  endtask

  task automatic test_load();
    run_instr(5, 3, 0);
    for (int i = 5; i <= 9; i++) run_instr(i, int'($urandom_range(0, 4)), 0);
  endtask

  task automatic test_store();
    run_instr(10, 0, 0);
    for (int i = 10; i <= 12; i++) run_instr(i, int'($urandom_range(0, 4)), 0);
  endtask

  task automatic test_branch_jump();
    for (int i = 13; i <= 16; i++) run_instr(i, 0, 0);
  endtask

  task automatic test_md();
    for (int i = 17; i <= 20; i++) run_instr(i, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr(21, 0, 0);
    run_instr(17, 0, 0);
  endtask

  task automatic test_async_reset();
    run_instr(17, 0, 4);
    run_instr(17, 0, 0);
    run_instr(5, 3, 5);
    run_instr(5, 1, 0);
    run_instr(11, 2, 4);
    run_instr(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++)
      run_instr(int'($urandom_range(0, NINS - 1)), int'($urandom_range(0, 3)), 0);
  endtask

  initial begin
    init_table();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch_jump();
    test_md();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
